// File: rtl/apb_req_arbiter.sv
// Two-requester round-robin arbiter feeding one APB master port.
// Every output is a flop; illegal targets burn a silent SETUP cycle before RESP.
module apb_req_arbiter #(
    parameter int unsigned TIMEOUT_CYC = 16
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        req0_valid,
    input  logic        req0_write,
    input  logic [1:0]  req0_tgt,
    input  logic [19:0] req0_addr,
    input  logic [15:0] req0_wdata,
    input  logic [1:0]  req0_strb,
    output logic        req0_ack,
    output logic        req0_done,
    input  logic        req1_valid,
    input  logic        req1_write,
    input  logic [1:0]  req1_tgt,
    input  logic [19:0] req1_addr,
    input  logic [15:0] req1_wdata,
    input  logic [1:0]  req1_strb,
    output logic        req1_ack,
    output logic        req1_done,
    output logic [15:0] rsp_rdata,
    output logic        rsp_err,
    output logic        rsp_timeout,
    output logic [1:0]  psel,
    output logic        penable,
    output logic        pwrite,
    output logic [1:0]  pstrb,
    output logic [19:0] paddr,
    output logic [15:0] pwdata,
    input  logic [15:0] prdata,
    input  logic        pready,
    input  logic        pslverr,
    output logic        busy
);

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_e;

    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT_CYC - 1);

    state_e      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        grant_q, grant_d;
    logic        last_q, last_d;
    logic        write_q, write_d;
    logic [1:0]  tgt_q, tgt_d;
    logic [19:0] addr_q, addr_d;
    logic [15:0] wdata_q, wdata_d;
    logic [1:0]  strb_q, strb_d;
    logic        ack0_q, ack0_d, ack1_q, ack1_d;
    logic        done0_q, done0_d, done1_q, done1_d;
    logic [15:0] rsp_rdata_q, rsp_rdata_d;
    logic        rsp_err_q, rsp_err_d;
    logic        rsp_timeout_q, rsp_timeout_d;
    logic [1:0]  psel_q, psel_d;
    logic        penable_q, penable_d;
    logic        pwrite_q, pwrite_d;
    logic [1:0]  pstrb_q, pstrb_d;
    logic [19:0] paddr_q, paddr_d;
    logic [15:0] pwdata_q, pwdata_d;
    logic        busy_q, busy_d;
    logic        pick1;
    logic        tgt_ok;
    logic        bus_on;

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        grant_d       = grant_q;
        last_d        = last_q;
        write_d       = write_q;
        tgt_d         = tgt_q;
        addr_d        = addr_q;
        wdata_d       = wdata_q;
        strb_d        = strb_q;
        rsp_rdata_d   = rsp_rdata_q;
        rsp_err_d     = rsp_err_q;
        rsp_timeout_d = rsp_timeout_q;
        ack0_d        = 1'b0;
        ack1_d        = 1'b0;
        done0_d       = 1'b0;
        done1_d       = 1'b0;
        // last_q names the requester served most recently; a tie goes to the other one
        pick1         = req1_valid && (!req0_valid || !last_q);

        unique case (state_q)
            IDLE: begin
                if (req0_valid || req1_valid) begin
                    grant_d = pick1;
                    ack0_d  = !pick1;
                    ack1_d  = pick1;
                    write_d = pick1 ? req1_write : req0_write;
                    tgt_d   = pick1 ? req1_tgt   : req0_tgt;
                    addr_d  = pick1 ? req1_addr  : req0_addr;
                    wdata_d = pick1 ? req1_wdata : req0_wdata;
                    strb_d  = pick1 ? req1_strb  : req0_strb;
                    cnt_d   = '0;
                    state_d = SETUP;
                end
            end
            SETUP: begin
                if (tgt_q == 2'b01 || tgt_q == 2'b10) begin
                    state_d = ACCESS;
                end else begin
                    rsp_rdata_d   = '0;
                    rsp_err_d     = 1'b1;
                    rsp_timeout_d = 1'b0;
                    state_d       = RESP;
                end
            end
            ACCESS: begin
                if (pready) begin
                    rsp_rdata_d   = write_q ? 16'h0000 : prdata;
                    rsp_err_d     = pslverr;
                    rsp_timeout_d = 1'b0;
                    state_d       = RESP;
                end else if (cnt_q == CNT_LAST) begin
                    rsp_rdata_d   = '0;
                    rsp_err_d     = 1'b1;
                    rsp_timeout_d = 1'b1;
                    state_d       = RESP;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            RESP: begin
                done0_d = !grant_q;
                done1_d = grant_q;
                last_d  = grant_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        tgt_ok    = (tgt_d == 2'b01) || (tgt_d == 2'b10);
        bus_on    = tgt_ok && (state_d == SETUP || state_d == ACCESS);
        psel_d    = bus_on ? tgt_d : 2'b00;
        penable_d = bus_on && (state_d == ACCESS);
        pwrite_d  = bus_on && write_d;
        pstrb_d   = bus_on ? strb_d : 2'b00;
        paddr_d   = bus_on ? addr_d : 20'h00000;
        pwdata_d  = bus_on ? wdata_d : 16'h0000;
        busy_d    = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            grant_q       <= 1'b0;
            last_q        <= 1'b1;
            write_q       <= 1'b0;
            tgt_q         <= '0;
            addr_q        <= '0;
            wdata_q       <= '0;
            strb_q        <= '0;
            ack0_q        <= 1'b0;
            ack1_q        <= 1'b0;
            done0_q       <= 1'b0;
            done1_q       <= 1'b0;
            rsp_rdata_q   <= '0;
            rsp_err_q     <= 1'b0;
            rsp_timeout_q <= 1'b0;
            psel_q        <= '0;
            penable_q     <= 1'b0;
            pwrite_q      <= 1'b0;
            pstrb_q       <= '0;
            paddr_q       <= '0;
            pwdata_q      <= '0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            grant_q       <= grant_d;
            last_q        <= last_d;
            write_q       <= write_d;
            tgt_q         <= tgt_d;
            addr_q        <= addr_d;
            wdata_q       <= wdata_d;
            strb_q        <= strb_d;
            ack0_q        <= ack0_d;
            ack1_q        <= ack1_d;
            done0_q       <= done0_d;
            done1_q       <= done1_d;
            rsp_rdata_q   <= rsp_rdata_d;
            rsp_err_q     <= rsp_err_d;
            rsp_timeout_q <= rsp_timeout_d;
            psel_q        <= psel_d;
            penable_q     <= penable_d;
            pwrite_q      <= pwrite_d;
            pstrb_q       <= pstrb_d;
            paddr_q       <= paddr_d;
            pwdata_q      <= pwdata_d;
            busy_q        <= busy_d;
        end
    end

    assign req0_ack    = ack0_q;
    assign req1_ack    = ack1_q;
    assign req0_done   = done0_q;
    assign req1_done   = done1_q;
    assign rsp_rdata   = rsp_rdata_q;
    assign rsp_err     = rsp_err_q;
    assign rsp_timeout = rsp_timeout_q;
    assign psel        = psel_q;
    assign penable     = penable_q;
    assign pwrite      = pwrite_q;
    assign pstrb       = pstrb_q;
    assign paddr       = paddr_q;
    assign pwdata      = pwdata_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_apb_req_arbiter.sv
// Directed bench for apb_req_arbiter: completions are checked against a queue of
// expected responses filled as each request is issued.
module tb_apb_req_arbiter;

    localparam int unsigned TO = 4;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        req0_valid, req0_write, req1_valid, req1_write;
    logic [1:0]  req0_tgt, req1_tgt, req0_strb, req1_strb;
    logic [19:0] req0_addr, req1_addr;
    logic [15:0] req0_wdata, req1_wdata;
    logic        req0_ack, req0_done, req1_ack, req1_done;
    logic [15:0] rsp_rdata;
    logic        rsp_err, rsp_timeout;
    logic [1:0]  psel, pstrb;
    logic        penable, pwrite;
    logic [19:0] paddr;
    logic [15:0] pwdata, prdata;
    logic        pready, pslverr, busy;

    always #5 clk = ~clk;

    apb_req_arbiter #(.TIMEOUT_CYC(TO)) dut (
        .clk(clk), .reset_n(reset_n),
        .req0_valid(req0_valid), .req0_write(req0_write), .req0_tgt(req0_tgt),
        .req0_addr(req0_addr), .req0_wdata(req0_wdata), .req0_strb(req0_strb),
        .req0_ack(req0_ack), .req0_done(req0_done),
        .req1_valid(req1_valid), .req1_write(req1_write), .req1_tgt(req1_tgt),
        .req1_addr(req1_addr), .req1_wdata(req1_wdata), .req1_strb(req1_strb),
        .req1_ack(req1_ack), .req1_done(req1_done),
        .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
        .psel(psel), .penable(penable), .pwrite(pwrite), .pstrb(pstrb),
        .paddr(paddr), .pwdata(pwdata),
        .prdata(prdata), .pready(pready), .pslverr(pslverr), .busy(busy)
    );

    typedef struct packed {
        logic        id;
        logic [15:0] rdata;
        logic        err;
        logic        tmo;
    } exp_t;

    exp_t sb[$];
    int   ack_log[$];
    int   tests_run = 0;
    int   tests_failed = 0;
    int   cyc = 0;
    int   ack_cyc = 0;
    int   done_cyc = 0;

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("[TB] FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t mk_exp(input logic id, input logic [15:0] rd, input logic err, input logic tmo);
        exp_t e;
        e.id    = id;
        e.rdata = rd;
        e.err   = err;
        e.tmo   = tmo;
        return e;
    endfunction

    // One cycle: sample on the falling edge, log acks, score any completion.
    task automatic tick();
        exp_t e;
        @(negedge clk);
        cyc++;
        if (req0_ack) begin ack_log.push_back(0); ack_cyc = cyc; end
        if (req1_ack) begin ack_log.push_back(1); ack_cyc = cyc; end
        check_output("ack_done_exclusive",
                     32'({req0_ack & req1_ack, req0_done & req1_done, req0_ack & req0_done, req1_ack & req1_done}),
                     32'd0);
        if (req0_done || req1_done) begin
            done_cyc = cyc;
            check_output("done_expected", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                check_output("done_id", 32'(req1_done), 32'(e.id));
                check_output("rsp_rdata", 32'(rsp_rdata), 32'(e.rdata));
                check_output("rsp_err", 32'(rsp_err), 32'(e.err));
                check_output("rsp_timeout", 32'(rsp_timeout), 32'(e.tmo));
            end
        end
    endtask

    task automatic apply_stimulus(input int n, input logic v, input logic w, input logic [1:0] tgt,
                                  input logic [19:0] a, input logic [15:0] d, input logic [1:0] s);
        if (n == 0) begin
            req0_valid = v; req0_write = w; req0_tgt = tgt;
            req0_addr = a; req0_wdata = d; req0_strb = s;
        end else begin
            req1_valid = v; req1_write = w; req1_tgt = tgt;
            req1_addr = a; req1_wdata = d; req1_strb = s;
        end
    endtask

    task automatic wait_done(input int budget);
        int n = 0;
        while (sb.size() != 0 && n < budget) begin
            tick();
            n++;
        end
        check_output("done_within_budget", 32'(sb.size()), 32'd0);
    endtask

    initial begin
        int   c0;
        int   n;
        int   pen_cnt;
        int   exp_order[4];
        logic last_srv;
        logic saw_bus;

        reset_n = 1'b0;
        apply_stimulus(0, 1'b0, 1'b0, 2'b00, 20'h0, 16'h0, 2'b00);
        apply_stimulus(1, 1'b0, 1'b0, 2'b00, 20'h0, 16'h0, 2'b00);
        prdata = 16'h0; pready = 1'b0; pslverr = 1'b0;
        tick();
        tick();
        check_output("rst_psel", 32'(psel), 32'd0);
        check_output("rst_penable", 32'(penable), 32'd0);
        check_output("rst_busy", 32'(busy), 32'd0);
        check_output("rst_paddr", 32'(paddr), 32'd0);
        check_output("rst_acks", 32'({req0_ack, req1_ack}), 32'd0);
        check_output("rst_dones", 32'({req0_done, req1_done}), 32'd0);
        check_output("rst_rsp", 32'({rsp_rdata, rsp_err, rsp_timeout}), 32'd0);
        reset_n = 1'b1;
        tick();
        check_output("idle_busy", 32'(busy), 32'd0);

        // Zero-wait read from req0: ack one cycle after the grant edge, done three after that.
        apply_stimulus(0, 1'b1, 1'b0, 2'b01, 20'h00C10, 16'h0, 2'b11);
        sb.push_back(mk_exp(1'b0, 16'h1234, 1'b0, 1'b0));
        c0 = cyc;
        tick();
        check_output("t1_ack0", 32'(req0_ack), 32'd1);
        check_output("t1_setup_psel", 32'(psel), 32'd1);
        check_output("t1_setup_penable", 32'(penable), 32'd0);
        check_output("t1_setup_paddr", 32'(paddr), 32'h00C10);
        check_output("t1_setup_busy", 32'(busy), 32'd1);
        req0_valid = 1'b0;
        pready = 1'b1; prdata = 16'h1234;
        tick();
        check_output("t1_access_penable", 32'(penable), 32'd1);
        check_output("t1_access_psel", 32'(psel), 32'd1);
        tick();
        pready = 1'b0;
        check_output("t1_resp_psel", 32'({psel, penable}), 32'd0);
        tick();
        check_output("t1_done0", 32'(req0_done), 32'd1);
        check_output("t1_done_latency", 32'(cyc - c0), 32'd4);
        last_srv = 1'b0;

        // Both requesters continuously pending: grants must alternate.
        ack_log.delete();
        for (int i = 0; i < 4; i++) begin
            exp_order[i] = last_srv ? 0 : 1;
            last_srv = ~last_srv;
            if (exp_order[i] == 0) sb.push_back(mk_exp(1'b0, 16'hBEEF, 1'b0, 1'b0));
            else sb.push_back(mk_exp(1'b1, 16'h0000, 1'b0, 1'b0));
        end
        apply_stimulus(0, 1'b1, 1'b0, 2'b01, 20'h00100, 16'h0, 2'b11);
        apply_stimulus(1, 1'b1, 1'b1, 2'b10, 20'h00200, 16'h7777, 2'b11);
        pready = 1'b1; prdata = 16'hBEEF;
        n = 0;
        while (ack_log.size() < 4 && n < 40) begin
            tick();
            n++;
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        check_output("t2_ack_count", 32'(ack_log.size()), 32'd4);
        wait_done(20);
        for (int i = 0; i < 4; i++)
            if (i < ack_log.size()) check_output("t2_grant_order", 32'(ack_log[i]), 32'(exp_order[i]));
        pready = 1'b0;
        tick();

        // req1 write with three wait states, ready on the final allowed cycle with slave error.
        apply_stimulus(1, 1'b1, 1'b1, 2'b10, 20'h12345, 16'hA5A5, 2'b10);
        sb.push_back(mk_exp(1'b1, 16'h0000, 1'b1, 1'b0));
        prdata = 16'hFFFF;
        tick();
        check_output("t3_ack1", 32'(req1_ack), 32'd1);
        check_output("t3_setup_attrs", 32'({psel, pwrite, pstrb, penable}), 32'b10_1_10_0);
        check_output("t3_setup_pwdata", 32'(pwdata), 32'hA5A5);
        check_output("t3_setup_paddr", 32'(paddr), 32'h12345);
        req1_valid = 1'b0;
        pen_cnt = 0; n = 0;
        while (sb.size() != 0 && n < 20) begin
            tick();
            n++;
            if (penable) begin
                pen_cnt++;
                check_output("t3_access_psel", 32'(psel), 32'd2);
                if (pen_cnt == 4) begin pready = 1'b1; pslverr = 1'b1; end
            end else begin
                pready = 1'b0; pslverr = 1'b0;
            end
        end
        pready = 1'b0; pslverr = 1'b0;
        check_output("t3_penable_cycles", 32'(pen_cnt), 32'd4);
        check_output("t3_completed", 32'(sb.size()), 32'd0);
        tick();

        // req0 read never answered: abort after TO access cycles.
        apply_stimulus(0, 1'b1, 1'b0, 2'b01, 20'h0ABCD, 16'h0, 2'b11);
        sb.push_back(mk_exp(1'b0, 16'h0000, 1'b1, 1'b1));
        tick();
        req0_valid = 1'b0;
        pen_cnt = 0; n = 0;
        while (sb.size() != 0 && n < 20) begin
            tick();
            n++;
            if (penable) pen_cnt++;
        end
        check_output("t4_penable_cycles", 32'(pen_cnt), 32'(TO));
        check_output("t4_completed", 32'(sb.size()), 32'd0);
        tick();

        // Illegal target: no bus activity, error response two cycles after ack.
        apply_stimulus(0, 1'b1, 1'b1, 2'b11, 20'h00055, 16'h1111, 2'b11);
        sb.push_back(mk_exp(1'b0, 16'h0000, 1'b1, 1'b0));
        saw_bus = 1'b0;
        tick();
        check_output("t5_ack0", 32'(req0_ack), 32'd1);
        req0_valid = 1'b0;
        saw_bus = saw_bus | (psel != 2'b00) | penable;
        n = 0;
        while (sb.size() != 0 && n < 10) begin
            tick();
            n++;
            saw_bus = saw_bus | (psel != 2'b00) | penable;
        end
        check_output("t5_no_psel", 32'(saw_bus), 32'd0);
        check_output("t5_done_gap", 32'(done_cyc - ack_cyc), 32'd2);
        tick();

        // Reset during ACCESS of a req1 transfer, then a tie must go to req0.
        apply_stimulus(1, 1'b1, 1'b0, 2'b01, 20'h00777, 16'h0, 2'b11);
        tick();
        check_output("t6_ack1", 32'(req1_ack), 32'd1);
        req1_valid = 1'b0;
        tick();
        check_output("t6_in_access", 32'(penable), 32'd1);
        reset_n = 1'b0;
        #1;
        check_output("t6_rst_apb", 32'({psel, penable, pwrite, pstrb}), 32'd0);
        check_output("t6_rst_paddr", 32'(paddr), 32'd0);
        check_output("t6_rst_busy", 32'(busy), 32'd0);
        apply_stimulus(0, 1'b1, 1'b0, 2'b01, 20'h00001, 16'h0, 2'b11);
        apply_stimulus(1, 1'b1, 1'b1, 2'b10, 20'h00002, 16'h2222, 2'b11);
        pready = 1'b1; prdata = 16'h5A5A;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_output("t6_no_done", 32'({req0_done, req1_done}), 32'd0);
        end
        reset_n = 1'b1;
        sb.push_back(mk_exp(1'b0, 16'h5A5A, 1'b0, 1'b0));
        tick();
        check_output("t6_tie_ack", 32'({req0_ack, req1_ack}), 32'b10);
        req0_valid = 1'b0; req1_valid = 1'b0;
        wait_done(10);
        pready = 1'b0;
        tick();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
